// File: rtl/cbfp_denorm.sv
// Block-floating-point exponent compensator: queues per-block shift indices and
// rescales each block of mantissa lanes back to a saturated fixed-point output.
module cbfp_denorm #(
  parameter int IN_WIDTH    = 11,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int DATA_NUM    = 16,
  parameter int BLOCK_BEATS = 4,
  parameter int SHIFT_POLE  = 12,
  parameter int IDX_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           idx_valid,
  input  logic        [SHIFT_WIDTH-1:0]  idx_in,
  output logic                           idx_ready,
  input  logic                           din_valid,
  input  logic signed [IN_WIDTH-1:0]     din_real [DATA_NUM],
  input  logic signed [IN_WIDTH-1:0]     din_imag [DATA_NUM],
  output logic                           dout_valid,
  output logic signed [OUT_WIDTH-1:0]    dout_real [DATA_NUM],
  output logic signed [OUT_WIDTH-1:0]    dout_imag [DATA_NUM],
  output logic [$clog2(IDX_DEPTH):0]     idx_count,
  output logic                           underflow_err
);

  localparam int PTR_W  = $clog2(IDX_DEPTH);
  localparam int BEAT_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam int EXT_W  = IN_WIDTH + SHIFT_POLE;

  localparam logic [SHIFT_WIDTH-1:0]  POLE    = SHIFT_WIDTH'(SHIFT_POLE);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [SHIFT_WIDTH-1:0] idx_mem [IDX_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]         count_reg;
  logic [BEAT_W-1:0]      beat_reg;
  logic [SHIFT_WIDTH-1:0] cur_idx_reg;
  logic                   underflow_reg;
  logic                   dout_valid_reg;

  logic                   full, empty, push, pop, block_start;
  logic [SHIFT_WIDTH-1:0] eff_idx;
  logic                   shift_left;
  logic [SHIFT_WIDTH-1:0] shift_amt;

  assign full        = (count_reg == (PTR_W+1)'(IDX_DEPTH));
  assign empty       = (count_reg == '0);
  assign push        = idx_valid && !full;
  assign block_start = din_valid && (beat_reg == '0);
  assign pop         = block_start && !empty;

  assign idx_ready     = !full;
  assign idx_count     = count_reg;
  assign underflow_err = underflow_reg;
  assign dout_valid    = dout_valid_reg;

  // Index storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) idx_mem[wr_ptr_reg] <= idx_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_reg       <= '0;
      cur_idx_reg    <= POLE;
      underflow_reg  <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= din_valid;
      if (din_valid) begin
        if (beat_reg == BEAT_W'(BLOCK_BEATS - 1)) beat_reg <= '0;
        else                                      beat_reg <= beat_reg + BEAT_W'(1);
      end
      if (block_start) cur_idx_reg <= eff_idx;
      if (block_start && empty) underflow_reg <= 1'b1;
    end
  end

  // Beat 0 takes the FIFO head directly; an empty FIFO falls back to unity scaling.
  always_comb begin
    eff_idx = cur_idx_reg;
    if (beat_reg == '0) eff_idx = empty ? POLE : idx_mem[rd_ptr_reg];
  end

  always_comb begin
    shift_left = (eff_idx <= POLE);
    shift_amt  = shift_left ? (POLE - eff_idx) : (eff_idx - POLE);
  end

  function automatic logic signed [OUT_WIDTH-1:0] denorm(
    input logic signed [IN_WIDTH-1:0] x,
    input logic                       left,
    input logic [SHIFT_WIDTH-1:0]     amt
  );
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shf;
    ext = {{SHIFT_POLE{x[IN_WIDTH-1]}}, x};
    shf = left ? (ext <<< amt) : (ext >>> amt);
    if (shf > SAT_MAX)      denorm = SAT_MAX[OUT_WIDTH-1:0];
    else if (shf < SAT_MIN) denorm = SAT_MIN[OUT_WIDTH-1:0];
    else                    denorm = shf[OUT_WIDTH-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DATA_NUM; gi++) begin : g_lane
      logic signed [OUT_WIDTH-1:0] re_next, im_next;
      logic signed [OUT_WIDTH-1:0] re_reg, im_reg;

      assign re_next = denorm(din_real[gi], shift_left, shift_amt);
      assign im_next = denorm(din_imag[gi], shift_left, shift_amt);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          re_reg <= '0;
          im_reg <= '0;
        end else if (din_valid) begin
          re_reg <= re_next;
          im_reg <= im_next;
        end
      end

      assign dout_real[gi] = re_reg;
      assign dout_imag[gi] = im_reg;
    end
  endgenerate

endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: constant vector table, directed corner
// sequences, and random traffic compared against a queue-based reference model.
module tb_cbfp_denorm;
  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              idx_valid;
  logic [4:0]        idx_in;
  logic              idx_ready;
  logic              din_valid;
  logic signed [10:0] din_real [N];
  logic signed [10:0] din_imag [N];
  logic              dout_valid;
  logic signed [15:0] dout_real [N];
  logic signed [15:0] dout_imag [N];
  logic [3:0]        idx_count;
  logic              underflow_err;

  cbfp_denorm dut (
    .clk(clk), .rstn(rstn),
    .idx_valid(idx_valid), .idx_in(idx_in), .idx_ready(idx_ready),
    .din_valid(din_valid), .din_real(din_real), .din_imag(din_imag),
    .dout_valid(dout_valid), .dout_real(dout_real), .dout_imag(dout_imag),
    .idx_count(idx_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int m_beat, m_cur;
  bit m_uf, m_dv;
  int m_re [N];
  int m_im [N];

  typedef struct {
    int idx; int re; int im; int exp_re; int exp_im;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_val(input int x, input int s);
    int v;
    int d;
    if (s <= 12) v = x * (1 << (12 - s));
    else begin
      d = 1 << (s - 12);
      v = x / d;
      if ((x % d) != 0 && x < 0) v = v - 1;
    end
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_beat = 0; m_cur = 12; m_uf = 0; m_dv = 0;
    for (int i = 0; i < N; i++) begin m_re[i] = 0; m_im[i] = 0; end
  endtask

  task automatic model_edge();
    int s;
    bit was_full;
    was_full = (q.size() >= 8);
    if (din_valid) begin
      if (m_beat == 0) begin
        if (q.size() > 0) s = q.pop_front();
        else begin s = 12; m_uf = 1; end
        m_cur = s;
      end else s = m_cur;
      for (int i = 0; i < N; i++) begin
        m_re[i] = ref_val(int'(din_real[i]), s);
        m_im[i] = ref_val(int'(din_imag[i]), s);
      end
      m_beat = (m_beat + 1) % 4;
    end
    if (idx_valid && !was_full) q.push_back(int'(idx_in));
    m_dv = din_valid;
  endtask

  task automatic check_state(input string tag);
    bit bad;
    chk({tag, "_idx_count"}, int'(idx_count), q.size());
    chk({tag, "_idx_ready"}, int'(idx_ready), int'(q.size() < 8));
    chk({tag, "_underflow"}, int'(underflow_err), int'(m_uf));
    chk({tag, "_dout_valid"}, int'(dout_valid), int'(m_dv));
    checks++;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (!bad && (int'(dout_real[i]) != m_re[i] || int'(dout_imag[i]) != m_im[i])) begin
        bad = 1;
        $display("FAIL %s_lanes: lane %0d got re=%0d im=%0d, expected re=%0d im=%0d",
                 tag, i, dout_real[i], dout_imag[i], m_re[i], m_im[i]);
      end
    end
    if (bad) errors++;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic set_lanes(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      din_real[i] = 11'(re);
      din_imag[i] = 11'(im);
    end
  endtask

  task automatic push_idx(input int idx);
    idx_valid = 1'b1; idx_in = 5'(idx);
    step("push");
    idx_valid = 1'b0;
  endtask

  task automatic beat_chk(input string tag, input int exp_re);
    din_valid = 1'b1;
    step(tag);
    din_valid = 1'b0;
    chk({tag, "_const"}, int'(dout_real[0]), exp_re);
  endtask

  initial begin
    tbl[0] = '{12,  100, -100,   100,   -100};
    tbl[1] = '{10,  300, -300,  1200,  -1200};
    tbl[2] = '{0,  1023, -1024, 32767, -32768};
    tbl[3] = '{15,   -9,    8,    -2,      1};
    tbl[4] = '{15,    7,   -8,     0,     -1};
    tbl[5] = '{14,  400, -400,   100,   -100};
    tbl[6] = '{31, 1023, -1024,    0,     -1};
    tbl[7] = '{13,   -1,    1,    -1,      0};

    rstn = 1'b0; idx_valid = 1'b0; idx_in = '0; din_valid = 1'b0;
    set_lanes(0, 0);
    model_reset();
    #12;
    check_state("reset");
    rstn = 1'b1;

    // Vector table: one block per record, constant lanes
    for (int r = 0; r < 8; r++) begin
      push_idx(tbl[r].idx);
      set_lanes(tbl[r].re, tbl[r].im);
      din_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
        step("tbl");
        chk("tbl_re", int'(dout_real[3]), tbl[r].exp_re);
        chk("tbl_im", int'(dout_imag[7]), tbl[r].exp_im);
      end
      din_valid = 1'b0;
      step("tbl_idle");
    end

    // Back-to-back blocks with mid-block gaps
    push_idx(10);
    push_idx(14);
    set_lanes(400, -400);
    beat_chk("b2b", 1600); beat_chk("b2b", 1600);
    step("gap");
    beat_chk("b2b", 1600); beat_chk("b2b", 1600);
    beat_chk("b2b", 100);
    step("gap"); step("gap");
    beat_chk("b2b", 100); beat_chk("b2b", 100); beat_chk("b2b", 100);

    // FIFO full: 9 consecutive idx_valid, the 9th is dropped
    idx_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      idx_in = 5'(4 + k);
      step("fill");
    end
    idx_valid = 1'b0;
    chk("full_count", int'(idx_count), 8);
    chk("full_ready", int'(idx_ready), 0);
    set_lanes(5, -5);
    din_valid = 1'b1;
    for (int k = 0; k < 32; k++) step("drain");
    din_valid = 1'b0;
    chk("drained_count", int'(idx_count), 0);
    chk("no_uf_yet", int'(underflow_err), 0);

    // Block started on an empty FIFO
    set_lanes(-5, 3);
    beat_chk("uf", -5);
    chk("uf_set", int'(underflow_err), 1);
    beat_chk("uf", -5); beat_chk("uf", -5); beat_chk("uf", -5);
    push_idx(12);
    chk("uf_sticky", int'(underflow_err), 1);

    // Reset after beat 2 of a block
    push_idx(11);
    set_lanes(50, 60);
    din_valid = 1'b1;
    step("pre_rst"); step("pre_rst"); step("pre_rst");
    din_valid = 1'b0;
    rstn = 1'b0;
    #2;
    model_reset();
    check_state("mid_rst");
    chk("rst_lane", int'(dout_real[0]), 0);
    #2 rstn = 1'b1;
    push_idx(11);
    set_lanes(50, 60);
    beat_chk("post_rst", 100);
    chk("post_rst_count", int'(idx_count), 0);
    chk("post_rst_uf", int'(underflow_err), 0);

    // Random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      idx_valid = ($urandom_range(0, 3) == 0);
      idx_in    = 5'($urandom_range(0, 31));
      din_valid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        din_real[i] = 11'($urandom_range(0, 2047));
        din_imag[i] = 11'($urandom_range(0, 2047));
      end
      step("rand");
    end
    idx_valid = 1'b0; din_valid = 1'b0;
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
